serial_subtractor_ctrl: RTL and testbench
=========================================

// Module: serial_subtractor_ctrl
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: sequences one Full_Subtractor cell LSB-first over
//  WIDTH cycles, holding the inter-bit borrow in a register. Computes op_a - op_b
//  (two's complement wrap) with final borrow. Start/ready/done handshake.
//  Area-cheap alternative to a WIDTH-wide ripple subtractor in the lab ALU datapath.
// PARAMETERS
//  WIDTH    8   operand/result width in bits; legal range 1..32
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      request; accepted only when ready=1
//  abort       in   1      synchronous cancel of a running operation
//  op_a        in   WIDTH  minuend, sampled on the accepting edge
//  op_b        in   WIDTH  subtrahend, sampled on the accepting edge
//  ready       out  1      1 in IDLE only
//  done        out  1      one-cycle pulse: result/borrow_out valid
//  result      out  WIDTH  difference op_a - op_b mod 2^WIDTH
//  borrow_out  out  1      1 iff op_a < op_b (unsigned)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready=1, done=0, result=0, borrow_out=0,
//   shift regs, borrow reg and bit counter = 0.
//  States: IDLE -> RUN -> DONE -> IDLE. Two-bit encoding IDLE=0, RUN=1, DONE=2; 3 unused -> IDLE.
//  IDLE: ready=1. start=1 on an edge: load sh_a<=op_a, sh_b<=op_b, brw<=0, cnt<=0,
//   state<=RUN. abort in IDLE has no effect. start=0: stay.
//  RUN: ready=0. Each edge: cell inputs (sh_a[0], sh_b[0], brw); sh_a, sh_b shift right
//   by 1; difference bit shifted into result shift reg at MSB; brw<=cell borrow; cnt++.
//   When cnt==WIDTH-1 on that edge -> DONE. start ignored (not queued).
//  DONE: done=1 for exactly one cycle; result=assembled difference, borrow_out=brw;
//   next edge -> IDLE unconditionally (start in DONE ignored).
//  Latency: start sampled at edge E -> done high in cycle after edge E+WIDTH
//   (WIDTH+1 edges); back-to-back throughput one op per WIDTH+2 cycles.
//  result/borrow_out update only on entry to DONE; held stable through IDLE until
//   the next completed op. Aborted ops never change them.
//  abort=1 in RUN: -> IDLE next edge, no done pulse, brw/cnt cleared. abort has
//   priority over the cnt==WIDTH-1 transition. abort in DONE ignored.
//  Reset mid-RUN: immediate return to reset values; no done pulse afterwards.
//  WIDTH=1: RUN lasts one edge; cnt width = max(1,$clog2(WIDTH)).
//  Wrap: result is mod 2^WIDTH; no overflow flag (signed overflow out of scope).
// STRUCTURE
//  Shared include sub_ctrl_defs.vh: state encodings ST_IDLE/ST_RUN/ST_DONE, WIDTH
//   legal-range limits.
//  One sub-module: existing Full_Subtractor instance u_fsub (A=sh_a[0], B=sh_b[0],
//   Borrow_in=brw); all other logic (FSM, counter, shift regs) in this module.
// TESTING
//  WIDTH=8, 100-37 -> done after 9 edges, result=8'd63, borrow_out=0, ready back next cycle.
//  WIDTH=8, 5-9 -> result=8'hFC, borrow_out=1; 8'hFF-8'h01 -> 8'hFE, 0; 0-0 -> 0, 0.
//  start pulsed at cycles 3 and 5 of a RUN -> ignored; exactly one done, first-op result.
//  abort at RUN cycle 4 -> IDLE next edge, no done, prior result/borrow_out unchanged;
//   new start then 200-1 -> 8'd199.
//  rst_n low mid-RUN -> all outputs to reset values immediately, ready=1, no done later.
//  WIDTH=1 build: 0-1 -> result=1, borrow_out=1, done 2 edges after start.

Source files
------------

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package serial_subtractor_ctrl_pkg;

  // Controller state encoding; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Legal operand width range.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_fsub.sv
// One-bit full subtractor cell: Diff = A - B - Borrow_in, Borrow_out on underflow.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B, Borrow_in (in); Diff, Borrow_out (out).
module Full_Subtractor (
  input  logic A,
  input  logic B,
  input  logic Borrow_in,
  output logic Diff,
  output logic Borrow_out
);

  assign Diff       = A ^ B ^ Borrow_in;
  // Borrow when B exceeds A, or when A==B and a borrow arrives from below.
  assign Borrow_out = (~A & B) | (~(A ^ B) & Borrow_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (op_a - op_b mod 2^WIDTH, final borrow), LSB first.
// Latency: start accepted at edge E -> done pulse in the cycle after edge E+WIDTH.
// Backpressure: start only accepted while ready=1; start during RUN/DONE is dropped.
// Ports: clk, rst_n, start, abort, op_a, op_b (in); ready, done, result, borrow_out (out).
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_e       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             cell_diff;
  logic             cell_brw;
  logic [WIDTH-1:0] d_next;

  Full_Subtractor u_fsub (
    .A          (sh_a[0]),
    .B          (sh_b[0]),
    .Borrow_in  (brw),
    .Diff       (cell_diff),
    .Borrow_out (cell_brw)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  // The concatenation form also covers WIDTH=1 without a degenerate slice.
  always_comb begin
    d_next = WIDTH'({cell_diff, sh_d} >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_d       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh_a  <= op_a;
            sh_b  <= op_b;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= ST_RUN;
            ready <= 1'b0;
          end
        end
        ST_RUN: begin
          // Abort wins over completion and never touches the published result.
          if (abort) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            brw   <= 1'b0;
            cnt   <= '0;
          end else begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            sh_d <= d_next;
            brw  <= cell_brw;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              result     <= d_next;
              borrow_out <= cell_brw;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8 and WIDTH=1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] op_a, op_b;
  logic       ready, done, borrow_out;
  logic [7:0] result;

  logic       start1, abort1;
  logic [0:0] op_a1, op_b1;
  logic       ready1, done1, borrow_out1;
  logic [0:0] result1;

  int errors = 0;
  int checks = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .ready(ready), .done(done),
    .result(result), .borrow_out(borrow_out)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .op_a(op_a1), .op_b(op_b1), .ready(ready1), .done(done1),
    .result(result1), .borrow_out(borrow_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic       exp_bo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an 8-bit op and count edges (including the accepting one) until done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int edges);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  vec_t vecs[7];
  int   edges;
  int   done_cnt;

  initial begin
    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'hFC,  1'b1};
    vecs[2] = '{8'hFF,  8'h01,  8'hFE,  1'b0};
    vecs[3] = '{8'h00,  8'h00,  8'h00,  1'b0};
    vecs[4] = '{8'd200, 8'd1,   8'd199, 1'b0};
    vecs[5] = '{8'h80,  8'h81,  8'hFF,  1'b1};
    vecs[6] = '{8'h55,  8'hAA,  8'hAB,  1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_a = '0; op_b = '0;
    start1 = 1'b0; abort1 = 1'b0; op_a1 = '0; op_b1 = '0;
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].a, vecs[i].b, edges);
      chk($sformatf("v%0d_latency", i), 32'(edges), 32'd9);
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_r));
      chk($sformatf("v%0d_borrow", i), 32'(borrow_out), 32'(vecs[i].exp_bo));
      chk($sformatf("v%0d_ready_in_done", i), 32'(ready), 32'd0);
      tick();
      chk($sformatf("v%0d_ready_back", i), 32'(ready), 32'd1);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start pulses during RUN are ignored: one done, first-op result.
    op_a = 8'd100; op_b = 8'd37; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 5) begin
        op_a = 8'd1; op_b = 8'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_cnt++;
        chk("ign_result", 32'(result), 32'd63);
        chk("ign_borrow", 32'(borrow_out), 32'd0);
      end
    end
    start = 1'b0;
    chk("ign_done_count", 32'(done_cnt), 32'd1);

    // Establish a known result, then abort the next op at RUN cycle 4.
    run8(8'd5, 8'd9, edges);
    tick();
    op_a = 8'd10; op_b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_result_held", 32'(result), 32'hFC);
    chk("abort_borrow_held", 32'(borrow_out), 32'd1);
    run8(8'd200, 8'd1, edges);
    chk("post_abort_latency", 32'(edges), 32'd9);
    chk("post_abort_result", 32'(result), 32'd199);
    chk("post_abort_borrow", 32'(borrow_out), 32'd0);
    tick();

    // Reset asserted mid-RUN.
    op_a = 8'd9; op_b = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_borrow", 32'(borrow_out), 32'd0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_ready_after", 32'(ready), 32'd1);

    // WIDTH=1 instance: done two edges after start edge counted.
    begin
      logic [2:0] w1 [3];
      w1[0] = 3'b011;  // a=0 b=1 -> r=1 bo=1
      w1[1] = 3'b101;  // a=1 b=0 -> r=1 bo=0
      w1[2] = 3'b110;  // a=1 b=1 -> r=0 bo=0
      for (int i = 0; i < 3; i++) begin
        logic [2:0] v;
        logic       er, eb;
        v = w1[i];
        er = v[2] ^ v[1];
        eb = ~v[2] & v[1];
        op_a1 = v[2]; op_b1 = v[1]; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        edges = 1;
        while (!done1 && edges < 10) begin
          tick();
          edges++;
        end
        chk($sformatf("w1_%0d_latency", i), 32'(edges), 32'd2);
        chk($sformatf("w1_%0d_result", i), 32'(result1), 32'(er));
        chk($sformatf("w1_%0d_borrow", i), 32'(borrow_out1), 32'(eb));
        tick();
        chk($sformatf("w1_%0d_ready", i), 32'(ready1), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
